lv_efuse_ld: RTL and testbench
==============================

# lv_efuse_ld

Low-voltage-side eFuse load controller. It sits directly upstream of the LV control FSM and answers that FSM's eFuse load request/done handshake. It reads every word of the eFuse macro into a shadow register and checks an XOR checksum. It then reports load completion and whether the eFuse contents are valid, which decides WAIT→TEST versus normal bring-up.

## Interface
Parameters:
- EFUSE_WORD_NUM, 8, number of eFuse words (≥2); the last word is the checksum.
- EFUSE_WORD_W, 8, bits per word.
- EFUSE_RD_CYC, 4, cycles the read strobe stays high per word (≥1).
- EFUSE_AW, $clog2(EFUSE_WORD_NUM), address width.

Ports:
- i_clk  in  1  clock (already decided).
- i_rst_n  in  1  reset, asynchronous, active-low (already decided).
- i_load_req  in  1  level load request from the control FSM.
- o_load_done  out  1  load finished; a level held until i_load_req falls.
- o_efuse_vld  out  1  shadow contents passed the checksum and are not blank.
- o_busy  out  1  high while a read sequence is in progress.
- o_efuse_rd_en  out  1  read strobe to the eFuse macro.
- o_efuse_addr  out  EFUSE_AW  word address to the macro.
- i_efuse_rdata  in  EFUSE_WORD_W  macro read data; stable by the last strobe cycle.
- o_efuse_data  out  EFUSE_WORD_NUM*EFUSE_WORD_W  shadow register; word k occupies bits [k*W +: W].

## Operation
- **Reset values:** all outputs 0, state IDLE, internal counters 0.
- **States:** IDLE, RD, GAP, CHK, DONE.
- **IDLE**
  - Goes to RD on i_load_req=1.
  - On that entry edge: shadow cleared to 0, o_efuse_vld←0, o_efuse_addr←0, o_efuse_rd_en←1, o_busy←1, strobe counter←0.
- **RD**
  - o_efuse_rd_en held high for exactly EFUSE_RD_CYC cycles.
  - On the edge that ends the last RD cycle: i_efuse_rdata is written into shadow word o_efuse_addr, o_efuse_rd_en←0, state→GAP.
- **GAP**
  - One cycle with the strobe low.
  - If o_efuse_addr==EFUSE_WORD_NUM-1: state→CHK.
  - Otherwise: addr+1, o_efuse_rd_en←1, state→RD.
- **CHK** (one cycle)
  - Valid condition: the XOR of words 0..N-2 equals word N-1, AND at least one of words 0..N-2 is nonzero.
  - On the edge ending CHK: o_efuse_vld←(valid condition), o_load_done←1, o_busy←0, state→DONE.
  - An all-zero (unprogrammed) array is therefore invalid.
- **DONE**
  - Holds o_load_done=1 while i_load_req=1.
  - When i_load_req=0: o_load_done←0, state→IDLE.
  - o_efuse_vld and o_efuse_data hold their values until the next load starts.
- **Abort**
  - If i_load_req=0 in RD, GAP or CHK, the next edge gives: state→IDLE, o_efuse_rd_en=0, o_busy=0, o_efuse_addr=0, o_load_done=0, o_efuse_vld=0.
  - The partially filled shadow is cleared to 0.
- **Reload:** a new i_load_req rising edge after DONE→IDLE repeats the full sequence, clearing vld and the shadow on start.
- **Address:** never exceeds EFUSE_WORD_NUM-1 and does not wrap within a load.

## Timing
- All outputs are registered; none are combinational from inputs.
- **Load latency:**
  - Edge E0 is the first edge that samples i_load_req=1 in IDLE.
  - o_load_done and o_efuse_vld become valid after edge E0 + EFUSE_WORD_NUM*(EFUSE_RD_CYC+1) + 1.
  - Default parameters: 41 cycles after E0.
- **Strobe pattern per word:** EFUSE_RD_CYC cycles high, then 1 cycle low. Address is stable throughout the strobe-high window.
- **Data capture:** i_efuse_rdata is sampled on the edge ending the last strobe-high cycle.
- **Handshake (4-phase):**
  - req↑ … done↑.
  - req↓ → done↓ one edge later.
  - req↑ while done=1 is impossible by construction.
  - req held low with done=0 keeps the block in IDLE.
- **Asynchronous reset mid-load:** immediate return to reset values; no partial data is retained.

## Test plan
- **Valid image:**
  - Macro words 0..6 = 01,02,04,08,10,20,40; word 7 = 7F; req held high.
  - Required: done=1 and vld=1 exactly 41 cycles after E0.
  - o_efuse_data = 0x7F40201008040201.
- **Blank image:**
  - All words 00; req high.
  - Required: done=1, vld=0 at cycle 41; FSM-side condition done&~vld is true.
- **Checksum error:**
  - Same data as the valid image but word 7 = 7E.
  - Required: done=1, vld=0, shadow holds 7E in the top byte.
- **Strobe/address check:**
  - Monitor the macro interface during the valid load.
  - Required: 8 bursts of rd_en, 4 cycles high and 1 low each.
  - Address 0..7 is stable within each burst; no rd_en after CHK.
- **Abort:**
  - Drop req on cycle 12 after E0 (word 2 in RD).
  - Required: next edge rd_en=0, busy=0, addr=0, done=0, vld=0, shadow=0.
  - Re-raise req: the full 41-cycle load completes correctly.
- **Reset mid-load:**
  - Assert i_rst_n=0 during word 5.
  - Required: all outputs 0 asynchronously.
  - After release with req high, a fresh load gives done at +41 cycles.

Source files
------------

// File: rtl/lv_efuse_ld.sv
// LV-side eFuse load controller: reads every macro word into a shadow register, verifies the
// XOR checksum and answers the control FSM's level load request/done handshake.
module lv_efuse_ld #(
    parameter int unsigned EFUSE_WORD_NUM = 8,
    parameter int unsigned EFUSE_WORD_W   = 8,
    parameter int unsigned EFUSE_RD_CYC   = 4,
    parameter int unsigned EFUSE_AW       = $clog2(EFUSE_WORD_NUM)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_load_req,
    output logic                                 o_load_done,
    output logic                                 o_efuse_vld,
    output logic                                 o_busy,
    output logic                                 o_efuse_rd_en,
    output logic [EFUSE_AW-1:0]                  o_efuse_addr,
    input  logic [EFUSE_WORD_W-1:0]              i_efuse_rdata,
    output logic [EFUSE_WORD_NUM*EFUSE_WORD_W-1:0] o_efuse_data
);

    localparam int unsigned CNT_W  = (EFUSE_RD_CYC > 1) ? $clog2(EFUSE_RD_CYC) : 1;
    localparam int unsigned DATA_W = EFUSE_WORD_NUM * EFUSE_WORD_W;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(EFUSE_RD_CYC - 1);
    localparam logic [EFUSE_AW-1:0] ADDR_LAST = EFUSE_AW'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {StIdle, StRd, StGap, StChk, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [EFUSE_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  vld_q, vld_d;
    logic [EFUSE_WORD_W-1:0] xor_acc;
    logic                  any_set;
    logic                  img_ok;

    // A blank (all-zero) array trivially satisfies the XOR, so it is rejected explicitly.
    always_comb begin
        xor_acc = '0;
        any_set = 1'b0;
        for (int k = 0; k < int'(EFUSE_WORD_NUM) - 1; k++) begin
            xor_acc = xor_acc ^ data_q[k*EFUSE_WORD_W +: EFUSE_WORD_W];
            any_set = any_set | (|data_q[k*EFUSE_WORD_W +: EFUSE_WORD_W]);
        end
        img_ok = any_set && (xor_acc == data_q[(EFUSE_WORD_NUM-1)*EFUSE_WORD_W +: EFUSE_WORD_W]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (i_load_req) state_d = StRd;
            StRd: begin
                if (!i_load_req)            state_d = StIdle;
                else if (cnt_q == CNT_LAST) state_d = StGap;
            end
            StGap: begin
                if (!i_load_req)              state_d = StIdle;
                else if (addr_q == ADDR_LAST) state_d = StChk;
                else                          state_d = StRd;
            end
            StChk:  state_d = i_load_req ? StDone : StIdle;
            StDone: if (!i_load_req) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rd_en_d = rd_en_q;
        busy_d  = busy_q;
        done_d  = done_q;
        vld_d   = vld_q;
        if ((state_q == StRd || state_q == StGap || state_q == StChk) && !i_load_req) begin
            // Abort: drop everything, including the partially filled shadow.
            cnt_d   = '0;
            addr_d  = '0;
            data_d  = '0;
            rd_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_load_req) begin
                        cnt_d   = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        rd_en_d = 1'b1;
                        busy_d  = 1'b1;
                        vld_d   = 1'b0;
                    end
                end
                StRd: begin
                    if (cnt_q == CNT_LAST) begin
                        data_d[int'(addr_q)*EFUSE_WORD_W +: EFUSE_WORD_W] = i_efuse_rdata;
                        rd_en_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (addr_q != ADDR_LAST) begin
                        addr_d  = addr_q + 1'b1;
                        rd_en_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
                StChk: begin
                    vld_d  = img_ok;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                StDone: if (!i_load_req) done_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
        end
    end

    assign o_load_done   = done_q;
    assign o_efuse_vld   = vld_q;
    assign o_busy        = busy_q;
    assign o_efuse_rd_en = rd_en_q;
    assign o_efuse_addr  = addr_q;
    assign o_efuse_data  = data_q;

endmodule

// File: tb/tb_lv_efuse_ld.sv
// Self-checking bench for lv_efuse_ld: image table with a result scoreboard, plus abort and
// mid-load reset sequences.
module tb_lv_efuse_ld;

    localparam int unsigned NW  = 8;
    localparam int unsigned WW  = 8;
    localparam int unsigned RDC = 4;
    localparam int unsigned AW  = 3;
    localparam int LAT = NW * (RDC + 1) + 1;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_load_req = 1'b0;
    logic            o_load_done, o_efuse_vld, o_busy, o_efuse_rd_en;
    logic [AW-1:0]   o_efuse_addr;
    logic [WW-1:0]   i_efuse_rdata;
    logic [NW*WW-1:0] o_efuse_data;

    logic [WW-1:0] mem [NW];

    typedef struct packed {
        logic [NW*WW-1:0] data;
        logic             vld;
    } exp_t;

    typedef struct packed {
        logic [NW*WW-1:0] img;
        logic             exp_vld;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 i_clk = ~i_clk;

    // Macro model: real data only while strobed, junk otherwise.
    assign i_efuse_rdata = o_efuse_rd_en ? mem[o_efuse_addr] : 8'hEE;

    lv_efuse_ld #(
        .EFUSE_WORD_NUM(NW),
        .EFUSE_WORD_W  (WW),
        .EFUSE_RD_CYC  (RDC),
        .EFUSE_AW      (AW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_req   (i_load_req),
        .o_load_done  (o_load_done),
        .o_efuse_vld  (o_efuse_vld),
        .o_busy       (o_busy),
        .o_efuse_rd_en(o_efuse_rd_en),
        .o_efuse_addr (o_efuse_addr),
        .i_efuse_rdata(i_efuse_rdata),
        .o_efuse_data (o_efuse_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " rd_en"}, 64'(o_efuse_rd_en), 64'd0);
        check({tag, " busy"},  64'(o_busy),        64'd0);
        check({tag, " addr"},  64'(o_efuse_addr),  64'd0);
        check({tag, " done"},  64'(o_load_done),   64'd0);
        check({tag, " vld"},   64'(o_efuse_vld),   64'd0);
        check({tag, " data"},  o_efuse_data,       64'd0);
    endtask

    task automatic start_load(input logic [NW*WW-1:0] img, input logic exp_vld);
        exp_t e;
        for (int k = 0; k < int'(NW); k++) mem[k] = img[k*WW +: WW];
        e.data = img;
        e.vld  = exp_vld;
        sb.push_back(e);
        @(negedge i_clk);
        i_load_req = 1'b1;
    endtask

    // Waits from E0 to done, monitoring the strobe bursts, then runs the release handshake.
    task automatic measure(input string tag);
        int   cyc = 0;
        int   run = 0;
        int   bursts = 0;
        int   burst_err = 0;
        int   addr_err = 0;
        logic [AW-1:0] baddr = '0;
        exp_t e;
        @(posedge i_clk);
        #1;
        while (1) begin
            if (o_efuse_rd_en) begin
                if (run == 0) baddr = o_efuse_addr;
                else if (o_efuse_addr != baddr) addr_err++;
                run++;
            end else if (run != 0) begin
                if (run != int'(RDC) || int'(baddr) != bursts) burst_err++;
                bursts++;
                run = 0;
            end
            if (o_load_done || cyc >= 100) break;
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(LAT));
        check({tag, " bursts"}, 64'(bursts), 64'(NW));
        check({tag, " burst shape"}, 64'(burst_err), 64'd0);
        check({tag, " addr stable"}, 64'(addr_err), 64'd0);
        check({tag, " busy at done"}, 64'(o_busy), 64'd0);
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " vld"}, 64'(o_efuse_vld), 64'(e.vld));
            check({tag, " data"}, o_efuse_data, e.data);
        end
        repeat (3) begin
            @(posedge i_clk);
            #1;
            check({tag, " done held"}, 64'(o_load_done), 64'd1);
            check({tag, " no strobe in done"}, 64'(o_efuse_rd_en), 64'd0);
        end
        @(negedge i_clk);
        i_load_req = 1'b0;
        @(posedge i_clk);
        #1;
        check({tag, " done release"}, 64'(o_load_done), 64'd0);
        check({tag, " vld hold"}, 64'(o_efuse_vld), 64'(e.vld));
        check({tag, " data hold"}, o_efuse_data, e.data);
        @(posedge i_clk);
        #1;
        check({tag, " idle strobe"}, 64'(o_efuse_rd_en), 64'd0);
        check({tag, " idle busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{img: 64'h7F40201008040201, exp_vld: 1'b1};
        vecs[1] = '{img: 64'h0000000000000000, exp_vld: 1'b0};
        vecs[2] = '{img: 64'h7E40201008040201, exp_vld: 1'b0};
        vecs[3] = '{img: 64'h0077665544332211, exp_vld: 1'b1};
        vecs[4] = '{img: 64'h8000000000000080, exp_vld: 1'b1};

        #12;
        check_idle_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check_idle_outputs("idle no req");

        for (int v = 0; v < 5; v++) begin
            start_load(vecs[v].img, vecs[v].exp_vld);
            measure($sformatf("vec%0d", v));
        end

        // Abort: drop req so the edge 12 after E0 sees it low (word 2 strobing).
        start_load(vecs[0].img, 1'b1);
        @(posedge i_clk);
        repeat (11) @(posedge i_clk);
        #1;
        check("abort pre addr", 64'(o_efuse_addr), 64'd2);
        check("abort pre rd_en", 64'(o_efuse_rd_en), 64'd1);
        @(negedge i_clk);
        i_load_req = 1'b0;
        @(posedge i_clk);
        #1;
        check_idle_outputs("abort");
        void'(sb.pop_back());  // cancelled load never completes
        start_load(vecs[0].img, 1'b1);
        measure("after abort");

        // Asynchronous reset while word 5 is being read.
        start_load(vecs[2].img, 1'b0);
        for (int i = 0; i < 100 && o_efuse_addr != 3'd5; i++) @(posedge i_clk);
        check("reset reach word5", 64'(o_efuse_addr), 64'd5);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        void'(sb.pop_back());
        exp_t_push: begin
            exp_t e;
            e.data = vecs[2].img;
            e.vld  = 1'b0;
            sb.push_back(e);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        measure("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
